// File: rtl/delay_chain_mem_mc_pkg.sv
// Shared types and helpers for the multi-channel RAM-backed delay line.
// All lanes share one ring, so its geometry lives here.
package delay_chain_pkg;

  localparam int MAX_LEN = 64;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int ADDR_W  = $clog2(MAX_LEN);

  typedef struct packed {
    logic [ADDR_W-1:0] ptr;
    logic [LW-1:0]     fill;
  } ring_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] length,
                                              input logic [LW-1:0] max_len);
    if (length > max_len) begin
      return max_len;
    end else begin
      return length;
    end
  endfunction

endpackage

// File: rtl/delay_chain_mem_mc_ram.sv
// Single-port read-first RAM: the read port shows the old word at i_addr
// during the cycle in which that word is overwritten.
module SpRamRf #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Storage write; no reset, fill gating upstream hides stale contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/delay_chain_mem_mc.sv
// Run-time-length multi-lane delay line over a read-first RAM ring, with a
// fill-gated output hold register and a combinational bypass for length 0.
module delay_chain_mem_mc
  import delay_chain_pkg::*;
#(
  parameter int DW = 8,
  parameter int CH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [LW-1:0]    i_length,
  input  logic [CH*DW-1:0] i_din,
  output logic [CH*DW-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [LW-1:0]    o_cur_len,
  output logic [LW-1:0]    o_fill_level
);

  localparam int WW = CH * DW;

  logic [LW-1:0]     r_len;
  logic [LW-1:0]     w_len_nxt;
  logic [LW-1:0]     w_len_eff;
  ring_t             r_ring;
  ring_t             w_ring_nxt;
  logic [WW-1:0]     r_dout;
  logic [WW-1:0]     w_dout_nxt;
  logic [WW-1:0]     w_rdata;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  fill_state_e       w_state;

  assign w_len_eff = clamp_len(i_length, LW'(MAX_LEN));

  SpRamRf #(
    .DW    (WW),
    .DEPTH (MAX_LEN)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (i_din),
    .o_rdata (w_rdata)
  );

  // Line state decoded from how many samples the ring holds.
  always_comb begin
    if ((r_len != '0) && (r_ring.fill == r_len)) begin
      w_state = ST_FULL;
    end else if (r_ring.fill == '0) begin
      w_state = ST_IDLE;
    end else begin
      w_state = ST_FILLING;
    end
  end

  // Next-state: flush beats a length restart, which beats a normal sample.
  always_comb begin
    w_len_nxt   = r_len;
    w_ring_nxt  = r_ring;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_we        = 1'b0;
    w_addr      = r_ring.ptr;
    if (i_flush) begin
      w_ring_nxt.ptr  = '0;
      w_ring_nxt.fill = '0;
      w_dout_nxt      = '0;
      w_valid_nxt     = 1'b0;
    end else if (i_en && (w_len_eff != r_len)) begin
      // The restart sample lands in slot 0, so the next one goes to slot 1.
      w_len_nxt       = w_len_eff;
      w_ring_nxt.ptr  = (w_len_eff > LW'(1)) ? ADDR_W'(1) : '0;
      w_ring_nxt.fill = (w_len_eff != '0) ? LW'(1) : '0;
      w_dout_nxt      = '0;
      w_valid_nxt     = 1'b0;
      w_we            = (w_len_eff != '0);
      w_addr          = '0;
    end else if (i_en && (r_len != '0)) begin
      w_we           = 1'b1;
      w_ring_nxt.ptr = (r_ring.ptr == ADDR_W'(r_len - LW'(1))) ? '0 : r_ring.ptr + ADDR_W'(1);
      if (w_state == ST_FULL) begin
        w_dout_nxt  = w_rdata;
        w_valid_nxt = 1'b1;
      end else begin
        w_dout_nxt      = '0;
        w_valid_nxt     = 1'b0;
        w_ring_nxt.fill = r_ring.fill + LW'(1);
      end
    end else begin
      w_we = 1'b0;
    end
  end

  // Control and output hold registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len   <= '0;
      r_ring  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_len   <= w_len_nxt;
      r_ring  <= w_ring_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign o_dout       = (r_len == '0) ? i_din : r_dout;
  assign o_dout_valid = (r_len == '0) ? i_en  : r_valid;
  assign o_cur_len    = r_len;
  assign o_fill_level = r_ring.fill;

endmodule
